uart_rx_assembler: RTL and testbench

UART_RX_ASSEMBLER -- requirements
Module: uart_rx_assembler

---
 rtl/uart_rx_assembler.sv | 133 +++++++++++++
 tb/tb_uart_rx_assembler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_assembler.sv
// Packs bytes from an upstream UART receiver into WORD_BYTES-wide words, first byte in the MSB.
// Optional inter-byte timeout is enabled by defining UART_RX_ASSEMBLER_TIMEOUT_EN.
module uart_rx_assembler #(
  parameter int CLOCK_RATE    = 10_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int WORD_BYTES    = 4,
  parameter int TIMEOUT_BYTES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              data,
  input  logic                    dataIsValid,
  output logic [8*WORD_BYTES-1:0] word,
  output logic                    wordValid,
  input  logic                    wordReady,
  output logic [3:0]              byteCount,
  output logic                    overrun,
  output logic                    timedOut
);

  localparam logic [3:0] LAST_IDX = 4'(WORD_BYTES - 1);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [8*WORD_BYTES-1:0] word_q, word_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    dv_q;
  logic                    armed_q;
  logic                    ovr_q, ovr_d;
  logic                    byte_evt;
  logic                    tmo_hit;

  // armed_q blocks a level that was already high when reset released from posing as an edge.
  assign byte_evt = dataIsValid & ~dv_q & armed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      word_q  <= '0;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
      armed_q <= ~dataIsValid;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      dv_q    <= dataIsValid;
      armed_q <= armed_q | ~dataIsValid;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    ovr_d   = 1'b0;
    case (state_q)
      COLLECT: begin
        if (byte_evt) begin
          word_d = {word_q[8*WORD_BYTES-9:0], data};
          if (cnt_q == LAST_IDX) begin
            state_d = HOLD;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else if (tmo_hit) begin
          word_d = '0;
          cnt_d  = '0;
        end
      end
      HOLD: begin
        // A byte arriving on the transfer cycle starts the next word instead of being dropped.
        if (wordReady) begin
          state_d = COLLECT;
          if (byte_evt) begin
            word_d = {word_q[8*WORD_BYTES-9:0], data};
            cnt_d  = 4'd1;
          end
        end else if (byte_evt) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

`ifdef UART_RX_ASSEMBLER_TIMEOUT_EN
  localparam int LIMIT = TIMEOUT_BYTES * ((10 * CLOCK_RATE) / BAUD_RATE);
  localparam int TW    = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [TW-1:0] tmo_q, tmo_d;
  logic          to_q;

  // Counts idle cycles of a partial word; a byte on the expiry cycle takes priority.
  always_comb begin
    tmo_hit = 1'b0;
    tmo_d   = tmo_q;
    if (byte_evt || (state_q != COLLECT) || (cnt_q == 4'd0)) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(LIMIT - 1)) begin
      tmo_hit = 1'b1;
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
      to_q  <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      to_q  <= tmo_hit;
    end
  end

  assign timedOut = to_q;
`else
  assign tmo_hit  = 1'b0;
  assign timedOut = 1'b0;
`endif

  assign word      = word_q;
  assign wordValid = (state_q == HOLD);
  assign byteCount = cnt_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_assembler.sv
// Self-checking bench for uart_rx_assembler: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_uart_rx_assembler;

  localparam int WB    = 4;
  localparam int LIMIT = 2 * ((10 * 10_000_000) / 115_200);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    data = 8'h00;
  logic          dataIsValid = 1'b0;
  logic [8*WB-1:0] word;
  logic          wordValid;
  logic          wordReady = 1'b1;
  logic [3:0]    byteCount;
  logic          overrun;
  logic          timedOut;

  int total = 0;
  int bad   = 0;
  int ovr_pulses = 0;
  int to_pulses  = 0;

  uart_rx_assembler dut (
    .clk(clk), .rst(rst), .data(data), .dataIsValid(dataIsValid),
    .word(word), .wordValid(wordValid), .wordReady(wordReady),
    .byteCount(byteCount), .overrun(overrun), .timedOut(timedOut)
  );

  always #5 clk = ~clk;

  // Reference model: bytes collected so far, whether a word is waiting, and idle time.
  byte unsigned m_bytes[$];
  bit           m_hold = 0;
  bit [31:0]    m_word = 0;
  bit           m_ovr = 0;
  bit           m_to = 0;
  bit           m_prev = 0;
  bit           m_armed = 0;
  int           m_idle = 0;
  bit           started = 0;

  always @(posedge clk) begin
    bit evt;
    started = 1;
    m_ovr = 0;
    m_to  = 0;
    if (rst) begin
      m_bytes.delete();
      m_hold  = 0;
      m_word  = 0;
      m_prev  = 0;
      m_armed = !dataIsValid;
      m_idle  = 0;
    end else begin
      evt = dataIsValid && !m_prev && m_armed;
      m_prev = dataIsValid;
      if (!dataIsValid) m_armed = 1;
      if (m_hold) begin
        if (wordReady) begin
          m_hold = 0;
          if (evt) m_bytes.push_back(data);
        end else if (evt) begin
          m_ovr = 1;
        end
        m_idle = 0;
      end else if (evt) begin
        m_bytes.push_back(data);
        m_idle = 0;
        if (m_bytes.size() == WB) begin
          m_word = 0;
          foreach (m_bytes[i]) m_word = m_word * 256 + 32'(m_bytes[i]);
          m_bytes.delete();
          m_hold = 1;
        end
      end else if (m_bytes.size() > 0) begin
        m_idle++;
`ifdef UART_RX_ASSEMBLER_TIMEOUT_EN
        if (m_idle == LIMIT) begin
          m_bytes.delete();
          m_idle = 0;
          m_to = 1;
        end
`endif
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check("m_wordValid", 64'(wordValid), 64'(m_hold));
      check("m_byteCount", 64'(byteCount), 64'(m_bytes.size()));
      check("m_overrun", 64'(overrun), 64'(m_ovr));
      check("m_timedOut", 64'(timedOut), 64'(m_to));
      if (m_hold) check("m_word", 64'(word), 64'(m_word));
      if (overrun === 1'b1) ovr_pulses++;
      if (timedOut === 1'b1) to_pulses++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge clk); #2;
    data = b;
    dataIsValid = 1'b1;
    repeat (hold) @(posedge clk);
    #2 dataIsValid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int hold);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], hold);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int ovr0;
    bit seen;
    idle(3);
    #1;
    check("reset_valid", 64'(wordValid), 64'd0);
    check("reset_count", 64'(byteCount), 64'd0);
    check("reset_word", 64'(word), 64'd0);
    rst = 1'b0;
    idle(2);

    // Basic word with downstream always ready
    send_word(32'h11223344, 1);
    #1;
    check("t1_valid", 64'(wordValid), 64'd1);
    check("t1_word", 64'(word), 64'h11223344);
    @(posedge clk); #1;
    check("t1_valid_fall", 64'(wordValid), 64'd0);
    idle(3);

    // Overrun while holding
    wordReady = 1'b0;
    send_word(32'h11223344, 1);
    ovr0 = ovr_pulses;
    send_byte(8'h55, 1);
    idle(3);
    check("t2_ovr_once", 64'(ovr_pulses - ovr0), 64'd1);
    check("t2_word_held", 64'(word), 64'h11223344);
    check("t2_still_valid", 64'(wordValid), 64'd1);
    wordReady = 1'b1;
    @(posedge clk); #1;
    check("t2_count_after", 64'(byteCount), 64'd0);
    check("t2_valid_after", 64'(wordValid), 64'd0);
    idle(2);

    // Byte event coinciding with the transfer
    wordReady = 1'b0;
    send_word(32'h01020304, 1);
    idle(2);
    data = 8'hAA;
    dataIsValid = 1'b1;
    wordReady = 1'b1;
    @(posedge clk); #2;
    dataIsValid = 1'b0;
    #1;
    check("t3_count1", 64'(byteCount), 64'd1);
    check("t3_valid0", 64'(wordValid), 64'd0);
    send_byte(8'hBB, 1);
    send_byte(8'hCC, 1);
    send_byte(8'hDD, 1);
    #1;
    check("t3_word", 64'(word), 64'hAABBCCDD);
    idle(3);

    // Reset mid-word
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    #1;
    check("t4_count", 64'(byteCount), 64'd0);
    check("t4_valid", 64'(wordValid), 64'd0);
    send_word(32'hCAFEF00D, 1);
    #1;
    check("t4_word", 64'(word), 64'hCAFEF00D);
    idle(3);

    // Level already high across reset release, with byte presented during reset
    data = 8'h77;
    dataIsValid = 1'b1;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(4);
    #1;
    check("t5_no_evt", 64'(byteCount), 64'd0);
    dataIsValid = 1'b0;
    idle(1);
    send_word(32'h0BADBEEF, 1);
    #1;
    check("t5_word", 64'(word), 64'h0BADBEEF);
    idle(3);

    // Long valid pulses count once each
    send_byte(8'h5A, 5);
    #1;
    check("t6_one_evt", 64'(byteCount), 64'd1);
    send_byte(8'h6B, 5);
    send_byte(8'h7C, 5);
    send_byte(8'h8D, 5);
    #1;
    check("t6_word", 64'(word), 64'h5A6B7C8D);
    idle(3);

`ifdef UART_RX_ASSEMBLER_TIMEOUT_EN
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    seen = 0;
    for (int i = 0; i < LIMIT + 20 && !seen; i++) begin
      @(negedge clk);
      if (timedOut === 1'b1) seen = 1;
    end
    check("t7_timeout_seen", 64'(seen), 64'd1);
    idle(1);
    check("t7_count", 64'(byteCount), 64'd0);
    send_word(32'hA1B2C3D4, 1);
    #1;
    check("t7_word", 64'(word), 64'hA1B2C3D4);
    idle(3);
    send_byte(8'h10, 1);
    idle(LIMIT - 3);
    send_byte(8'h20, 1);
    idle(LIMIT + 5);
    check("t7_late_timeout", 64'(byteCount), 64'd0);
`else
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    idle(LIMIT + 20);
    check("t7_no_timeout_count", 64'(byteCount), 64'd2);
    check("t7_no_timeout_pulse", 64'(to_pulses), 64'd0);
    send_byte(8'hC3, 1);
    send_byte(8'hD4, 1);
    #1;
    check("t7_word", 64'(word), 64'h0102C3D4);
    idle(3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, limit %0d ns", 2_000_000);
    $fatal(1);
  end

endmodule
